// File: rtl/servo_pwm_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_driver_if
//  Description : Angle targets, enable, PWM pins and settled flag shared
//                between the arm angle logic and the servo PWM driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface servo_pwm_driver_if;
    logic [7:0] angle1;
    logic [7:0] angle2;
    logic [7:0] angle3;
    logic [7:0] angle4;
    logic       enable;
    logic       pwm1;
    logic       pwm2;
    logic       pwm3;
    logic       pwm4;
    logic       settled;

    modport master (
        output angle1, angle2, angle3, angle4, enable,
        input  pwm1, pwm2, pwm3, pwm4, settled
    );

    modport slave (
        input  angle1, angle2, angle3, angle4, enable,
        output pwm1, pwm2, pwm3, pwm4, settled
    );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_driver
//  Description : Four-channel hobby-servo PWM generator. Each channel slews
//                toward its clamped angle target by at most STEP_DEG per
//                frame; targets and enable are sampled only at frame
//                boundaries so a pulse in progress is never altered.
//  Revision    : 1.0  initial release
// ============================================================================
module servo_pwm_driver #(
    parameter int PERIOD_CYCLES  = 1_000_000,
    parameter int MIN_PULSE      = 25_000,
    parameter int CYCLES_PER_DEG = 555,
    parameter int STEP_DEG       = 1,
    parameter int INIT_DEG       = 90
) (
    input  logic               clk,
    input  logic               rst,
    servo_pwm_driver_if.slave  bus
);

    // Counter and pulse width share one width, never narrower than 17 bits.
    localparam int C_CNT_BITS = $clog2(PERIOD_CYCLES + 1);
    localparam int C_W        = (C_CNT_BITS > 17) ? C_CNT_BITS : 17;

    localparam logic [C_W-1:0] C_LAST    = C_W'(PERIOD_CYCLES - 1);
    localparam logic [C_W-1:0] C_MIN     = C_W'(MIN_PULSE);
    localparam logic [C_W-1:0] C_CPD     = C_W'(CYCLES_PER_DEG);
    localparam logic [7:0]     C_MAX_DEG = 8'd180;
    // A step larger than the full travel behaves like the full travel.
    localparam logic [7:0]     C_STEP    = (STEP_DEG > 180) ? 8'd180 : 8'(STEP_DEG);
    localparam logic [7:0]     C_INIT    = 8'(INIT_DEG);

    logic [C_W-1:0]  r_cnt;
    logic [C_W-1:0]  w_cnt_next;
    logic            w_boundary;
    logic            r_enable_q;
    logic            w_enable_next;
    logic [3:0][7:0] w_angle;
    logic [3:0]      w_at_tgt;
    logic [3:0]      w_pwm_next;
    logic [3:0]      r_pwm;
    logic            r_settled;

    assign w_angle       = {bus.angle4, bus.angle3, bus.angle2, bus.angle1};
    assign w_boundary    = (r_cnt == C_LAST);
    assign w_cnt_next    = w_boundary ? '0 : r_cnt + 1'b1;
    // Enable only takes effect at the frame boundary.
    assign w_enable_next = w_boundary ? bus.enable : r_enable_q;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [7:0]     r_pos;
        logic [7:0]     w_tgt;
        logic [7:0]     w_slewed;
        logic [7:0]     w_pos_eff;
        logic [C_W-1:0] w_width;

        // Clamp the target and move at most one step toward it, never past it.
        always_comb begin
            w_tgt    = (w_angle[i] > C_MAX_DEG) ? C_MAX_DEG : w_angle[i];
            w_slewed = r_pos;
            if (r_pos < w_tgt) begin
                w_slewed = r_pos + (((w_tgt - r_pos) > C_STEP) ? C_STEP : (w_tgt - r_pos));
            end else if (r_pos > w_tgt) begin
                w_slewed = r_pos - (((r_pos - w_tgt) > C_STEP) ? C_STEP : (r_pos - w_tgt));
            end
        end

        // Position moves only at an enabled boundary; mid-frame it is frozen,
        // so the width of the pulse in progress cannot change.
        assign w_pos_eff      = (w_boundary && bus.enable) ? w_slewed : r_pos;
        assign w_width        = C_MIN + C_W'(w_pos_eff) * C_CPD;
        assign w_at_tgt[i]    = (w_pos_eff == w_tgt);
        assign w_pwm_next[i]  = w_enable_next && (w_cnt_next < w_width);

        // Per-channel position register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pos <= C_INIT;
            end else begin
                r_pos <= w_pos_eff;
            end
        end
    end

    // Frame counter, sampled enable, registered PWM pins and settled flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_enable_q <= 1'b0;
            r_pwm      <= '0;
            r_settled  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_enable_q <= w_enable_next;
            r_pwm      <= w_pwm_next;
            if (w_boundary) begin
                r_settled <= bus.enable && (&w_at_tgt);
            end
        end
    end

    assign bus.pwm1    = r_pwm[0];
    assign bus.pwm2    = r_pwm[1];
    assign bus.pwm3    = r_pwm[2];
    assign bus.pwm4    = r_pwm[3];
    assign bus.settled = r_settled;

endmodule
`default_nettype wire
